and_16bit_bist: RTL

//   Built-in self-test engine for the 16-bit AND chip. It drives the chip's a/b

---
 rtl/and_16bit_bist_if.sv | 38 +++
 rtl/and_16bit_bist.sv | 130 +++++++++++++
 2 files changed

// File: rtl/and_16bit_bist_if.sv
// Bus between the BIST engine and its controller / chip under test.
// The master side is the BIST engine: it drives the chip inputs and status, and samples start and the chip output.
`timescale 1ns/1ps
interface and_16bit_bist_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_count;
    logic [7:0]  first_fail_idx;
    logic [15:0] dut_a;
    logic [15:0] dut_b;
    logic [15:0] dut_out;

    modport master (
        input  start,
        input  dut_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_idx,
        output dut_a,
        output dut_b
    );

    modport slave (
        output start,
        output dut_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_idx,
        input  dut_a,
        input  dut_b
    );
endinterface

// File: rtl/and_16bit_bist.sv
// BIST engine for a 16-bit AND chip: 4 fixed vectors followed by NUM_RAND Galois-LFSR vectors.
// Each vector takes two cycles (APPLY drives the chip, CHECK compares its output).
`timescale 1ns/1ps
module and_16bit_bist #(
    parameter int          NUM_RAND = 64,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    and_16bit_bist_if.master bist_if
);
    localparam logic [7:0]  LAST_IDX = 8'(3 + NUM_RAND);
    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  ffi_q, ffi_d;
    logic        pass_q, pass_d;

    logic [15:0] vec_a, vec_b;
    logic [15:0] lfsr_step;
    logic        mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            lfsr_q  <= SEED_EFF;
            exp_q   <= 16'h0000;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            err_q   <= 8'd0;
            ffi_q   <= 8'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            exp_q   <= exp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            pass_q  <= pass_d;
        end
    end

    // Vector generator: fixed patterns first, then LFSR value and its byte-swapped complement.
    always_comb begin
        vec_a = lfsr_q;
        vec_b = ~{lfsr_q[7:0], lfsr_q[15:8]};
        case (idx_q)
            8'd0: begin vec_a = 16'h0000; vec_b = 16'h0000; end
            8'd1: begin vec_a = 16'h0000; vec_b = 16'hFFFF; end
            8'd2: begin vec_a = 16'hFFFF; vec_b = 16'hFFFF; end
            8'd3: begin vec_a = 16'hAAAA; vec_b = 16'h5555; end
            default: ;
        endcase
    end

    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign mismatch  = (bist_if.dut_out != exp_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        exp_d   = exp_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (bist_if.start) begin
                    state_d = APPLY;
                    idx_d   = 8'd0;
                    lfsr_d  = SEED_EFF;
                    err_d   = 8'd0;
                    ffi_d   = 8'd0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                a_d     = vec_a;
                b_d     = vec_b;
                exp_d   = vec_a & vec_b;
                state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 8'd1;
                    if (err_q == 8'd0) begin
                        ffi_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    // pass must already account for this final comparison.
                    pass_d  = (err_q == 8'd0) && !mismatch;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q >= 8'd4) begin
                        lfsr_d = lfsr_step;
                    end
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bist_if.busy           = (state_q == APPLY) || (state_q == CHECK);
    assign bist_if.done           = (state_q == DONE);
    assign bist_if.pass           = pass_q;
    assign bist_if.err_count      = err_q;
    assign bist_if.first_fail_idx = ffi_q;
    assign bist_if.dut_a          = a_q;
    assign bist_if.dut_b          = b_q;
endmodule
